// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master modport is the byte source / memory side, the slave modport
// is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Parses a byte stream of the form
// {count lo, count hi, N x (word lo, word hi), xor checksum}, writes each
// word to instruction memory and releases the processor reset only after
// the whole image has been written and the checksum matched.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;        // one extra bit so N = depth never wraps
  logic [7:0]            xor_q, xor_d;        // running XOR of data bytes only
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            lo_q, lo_d;          // low byte of the word in flight
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wdata_q, mem_wdata_d;

  logic                  in_ready_w;
  logic                  accept;
  logic [15:0]           n_w;
  logic [31:0]           idx_inc_w;

  // in_ready depends only on the state register, never on in_valid.
  assign in_ready_w = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                      (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                      (state_q == S_CHK);
  assign accept     = bus.in_valid && in_ready_w;
  assign n_w        = {bus.in_byte, cnt_lo_q};
  assign idx_inc_w  = 32'(idx_q) + 32'd1;

  assign bus.in_ready  = in_ready_w;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = in_ready_w;
  assign cpu_reset     = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);

  // Next-state, datapath updates and the one-cycle write pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    cnt_lo_d    = cnt_lo_q;
    count_d     = count_q;
    lo_d        = lo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_CNT_LO;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_lo_d = bus.in_byte;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          count_d = n_w;
          if ((n_w == 16'd0) || (32'(n_w) > MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = bus.in_byte;
          xor_d   = xor_q ^ bus.in_byte;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q[ADDR_WIDTH-1:0];
          mem_wdata_d = {bus.in_byte, lo_q};
          xor_d       = xor_q ^ bus.in_byte;
          idx_d       = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (idx_inc_w < 32'(count_q)) begin
            state_d = S_DATA_LO;
          end else begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (bus.in_byte == xor_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      xor_q       <= '0;
      cnt_lo_q    <= '0;
      count_q     <= '0;
      lo_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      cnt_lo_q    <= cnt_lo_d;
      count_q     <= count_d;
      lo_q        <= lo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the stimulus side computes the expected
// memory writes and final status from the image, a monitor compares writes.
module tb_imem_loader;

  localparam int AW = 10;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [15:0] img[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Compares every memory write against the expected-write queue.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(bus.mem_addr), e.addr);
          chk("wr_data", int'(bus.mem_wdata), e.data);
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_cpu_reset", int'(cpu_reset), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_err_clr", int'(error), 0);
  endtask

  // gmode 0: back-to-back, 1: one idle cycle before each byte,
  // 2: random idle cycles with stray start pulses while busy.
  task automatic send_byte(input logic [7:0] b, input int gmode);
    int  gaps;
    bit  acc;
    gaps = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(2)) : 0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      start = (gmode == 2) && ($urandom_range(3) == 0);
      chk("ready_in_gap", int'(bus.in_ready), 1);
    end
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_byte = b;
      acc = bus.in_ready;
      @(posedge clk);
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // Streams count n and (if n is legal) the words in img, then checks the
  // outcome one cycle after the last accepted byte.
  task automatic run_load(input int n, input bit bad, input int gmode);
    bit         valid;
    bit         ok;
    logic [7:0] x;
    logic [7:0] cs;
    logic [15:0] w;
    wr_t        e;
    valid = (n >= 1) && (n <= (1 << AW));
    x = 8'h00;
    do_start();
    send_byte(n[7:0], gmode);
    send_byte(n[15:8], gmode);
    if (valid) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        e.addr = i;
        e.data = int'(w);
        exp_q.push_back(e);
        x = x ^ w[7:0] ^ w[15:8];
        send_byte(w[7:0], gmode);
        send_byte(w[15:8], gmode);
      end
      cs = bad ? (x ^ 8'h01) : x;
      send_byte(cs, gmode);
    end
    ok = valid && !bad;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("end_done", int'(done), int'(ok));
    chk("end_error", int'(error), int'(!ok));
    chk("end_cpu_reset", int'(cpu_reset), int'(!ok));
    chk("end_in_ready", int'(bus.in_ready), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_cpu_reset", int'(cpu_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;

    // Two-word image, back-to-back, then stray bytes after DONE.
    img = {16'h1234, 16'hABCD};
    run_load(2, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_byte = 8'h5A;
      chk("idle_in_ready", int'(bus.in_ready), 0);
      chk("idle_done_sticky", int'(done), 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Same image with in_valid toggling, then with a bad checksum.
    run_load(2, 1'b0, 1);
    run_load(2, 1'b1, 0);

    // Illegal counts: zero and depth+1.
    run_load(0, 1'b0, 0);
    run_load(1025, 1'b0, 0);

    // Full-depth image, words equal to their index.
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(16'(i));
    run_load(1024, 1'b0, 0);

    // Reset after the third data byte of an N=4 load.
    begin
      wr_t e;
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back(16'($urandom));
      do_start();
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      e.addr = 0;
      e.data = int'(img[0]);
      exp_q.push_back(e);
      send_byte(img[0][7:0], 0);
      send_byte(img[0][15:8], 0);
      send_byte(img[1][7:0], 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_mem_we", int'(bus.mem_we), 0);
      chk("midrst_cpu_reset", int'(cpu_reset), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_in_ready", int'(bus.in_ready), 0);
      chk("midrst_pending", exp_q.size(), 0);
      img.delete();
      img.push_back(16'hBEEF);
      run_load(1, 1'b0, 0);
    end

    // Randomized images with random gaps, stray starts and bad checksums.
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 12));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      run_load(n, ($urandom_range(3) == 0), 2);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the processor's 16-bit instruction memory from a byte stream. It sits between a byte source (host link or ROM streamer) and the instruction memory write port. It holds the processor in reset until a complete, checksum-verified image has been written. It is the writer for the instruction memory that the processor's fetch stage reads.

## Interface
- ADDR_WIDTH, 10, instruction memory address width; depth is 2**ADDR_WIDTH words
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE, ERR
- in_valid  input  1  byte source has a byte on in_byte
- in_byte  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  output  ADDR_WIDTH  write address
- mem_wdata  output  16  write data
- cpu_reset  output  1  processor reset; high except in DONE
- busy  output  1  load in progress (states CNT_LO through CHK)
- done  output  1  image loaded and verified; sticky until the next start or reset
- error  output  1  bad count or checksum; sticky until the next start or reset

## Operation
- Stream format: count low byte, count high byte (N = number of words, 16-bit), then N words, each sent as low byte then high byte, then one checksum byte equal to the XOR of all 2N data bytes.
- States: IDLE, CNT_LO, CNT_HI, DATA_LO, DATA_HI, CHK, DONE, ERR.
- IDLE --start--> CNT_LO. CNT_LO --accept--> CNT_HI. CNT_HI --accept--> DATA_LO, or to ERR if N == 0 or N > 2**ADDR_WIDTH.
- DATA_LO --accept--> DATA_HI. DATA_HI --accept--> DATA_LO if the word index + 1 < N, otherwise CHK.
- CHK --accept--> DONE if the byte equals the running XOR, otherwise ERR.
- DONE or ERR --start--> CNT_LO. In that cycle done and error clear, and the word index and XOR reset to 0.
- in_ready = 1 only in CNT_LO, CNT_HI, DATA_LO, DATA_HI, CHK.
- Word index is an (ADDR_WIDTH+1)-bit counter, reset to 0 on start. It increments on each DATA_HI accept and never wraps, because N is bounded by 2**ADDR_WIDTH.
- Running XOR covers data bytes only, not the count bytes.
- Write on a DATA_HI accept: on the next cycle mem_we = 1, mem_addr = index (before increment), mem_wdata = {in_byte, stored low byte}.
- On a checksum mismatch, words already written stay in memory and cpu_reset stays 1.
- start while busy is ignored.
- in_valid outside the in_ready states is ignored; no byte is consumed.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, index 0, XOR 0.
- Reset mid-load aborts at the next edge: mem_we 0, no further writes, cpu_reset 1, and a pending write is dropped.
- All outputs are registered or decoded from the state register. No combinational path from in_valid to in_ready.
- One byte per cycle maximum. Back-to-back in_valid is accepted with no bubbles; a full image takes 2N+3 accepting cycles.
- mem_we lags the high-byte accept by 1 cycle.
- The final word's mem_we falls in the same cycle the FSM is in CHK, so the write overlaps checksum reception.
- done rises and cpu_reset falls together, on the edge after the checksum accept. The processor leaves reset on that cycle and fetches address 0.
- error rises on the edge after the offending byte accept.
- cpu_reset rises on the edge where start is taken from DONE.

## Test plan
- Load N=2 words 0x1234, 0xABCD via bytes 02 00 34 12 CD AB, checksum 0x34^0x12^0xCD^0xAB = 0x40, streamed back-to-back.
  - Required: writes (addr 0, 0x1234) then (addr 1, 0xABCD); done=1 and cpu_reset=0 one cycle after the 0x40 accept.
- Same image with in_valid toggling every other cycle.
  - Required: identical writes; no byte lost or duplicated; in_ready stays high throughout the load.
- Same image with checksum 0x41.
  - Required: both words written, then error=1, done=0, cpu_reset=1, in_ready=0.
- Count 00 00, and separately count 01 04 (N=1025, ADDR_WIDTH=10).
  - Required: error=1 after the second count byte; no mem_we pulse.
- N=1024 image of words equal to their index.
  - Required: the last write is at addr 0x3FF with data 0x03FF; the index does not wrap; done=1.
- Assert reset after the 3rd data byte of an N=4 load, then start a new N=1 load.
  - Required: after reset, mem_we=0 and cpu_reset=1 in IDLE; the new load writes addr 0 and finishes with done=1.
